// File: rtl/robot_pkg.sv
// Shared state codes, counter widths and action timing constants for the wall-following robot.
package robot_pkg;

    localparam int unsigned STATE_W          = 3;
    localparam int unsigned CNT_W            = 2;
    localparam int unsigned REMOVE_CYCLES    = 3;
    localparam int unsigned RIGHT_TURN_EXTRA = 2;

    typedef enum logic [STATE_W-1:0] {
        SEARCH        = 3'b000,
        ROTATE        = 3'b001,
        REMOVE_FOLLOW = 3'b010,
        STAND_BY      = 3'b011,
        FIRST_MOVE    = 3'b100,
        RESETTING     = 3'b101
    } state_t;

    typedef struct packed {
        logic front;
        logic turn;
        logic remove;
    } action_t;

endpackage

// File: rtl/robot.sv
// Left-hand wall-following robot controller: one registered action per cycle from the
// head/left/barrier/under sensors, with locked-in right turns and trash removal bursts.
module robot
    import robot_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic head,
    input  logic left,
    input  logic under,
    input  logic barrier,
    output logic front,
    output logic turn,
    output logic remove
);

    state_t             act_state;
    state_t             next_state;
    state_t             ret_state;
    state_t             ret_state_nxt;
    logic [CNT_W-1:0]   rot_cnt;
    logic [CNT_W-1:0]   rot_cnt_nxt;
    logic [CNT_W-1:0]   rem_cnt;
    logic [CNT_W-1:0]   rem_cnt_nxt;
    logic               follow;
    logic               follow_nxt;
    logic               search_dec;
    action_t            act_nxt;

    // State register and registered action outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            act_state <= RESETTING;
            ret_state <= SEARCH;
            rot_cnt   <= '0;
            rem_cnt   <= '0;
            follow    <= 1'b0;
            front     <= 1'b0;
            turn      <= 1'b0;
            remove    <= 1'b0;
        end else begin
            act_state <= next_state;
            ret_state <= ret_state_nxt;
            rot_cnt   <= rot_cnt_nxt;
            rem_cnt   <= rem_cnt_nxt;
            follow    <= follow_nxt;
            front     <= act_nxt.front;
            turn      <= act_nxt.turn;
            remove    <= act_nxt.remove;
        end
    end

    // Next-state and next-action decision
    always_comb begin
        next_state    = act_state;
        ret_state_nxt = ret_state;
        rot_cnt_nxt   = rot_cnt;
        rem_cnt_nxt   = rem_cnt;
        follow_nxt    = follow;
        act_nxt       = '0;
        search_dec    = 1'b0;

        if (act_state == RESETTING) begin
            next_state = FIRST_MOVE;
        end else if (under) begin
            next_state  = STAND_BY;
            rot_cnt_nxt = '0;
            rem_cnt_nxt = '0;
            follow_nxt  = 1'b0;
        end else begin
            case (act_state)
                STAND_BY: begin
                    next_state = STAND_BY;
                end
                FIRST_MOVE: begin
                    if (left) begin
                        search_dec = 1'b1;
                    end else if (barrier) begin
                        act_nxt.remove = 1'b1;
                        rem_cnt_nxt    = CNT_W'(REMOVE_CYCLES - 1);
                        ret_state_nxt  = FIRST_MOVE;
                        next_state     = REMOVE_FOLLOW;
                    end else if (!head) begin
                        act_nxt.front = 1'b1;
                    end else begin
                        act_nxt.turn = 1'b1;
                    end
                end
                SEARCH: begin
                    search_dec = 1'b1;
                end
                ROTATE: begin
                    act_nxt.turn = 1'b1;
                    if (rot_cnt > CNT_W'(1)) begin
                        rot_cnt_nxt = rot_cnt - CNT_W'(1);
                    end else begin
                        rot_cnt_nxt = '0;
                        next_state  = SEARCH;
                    end
                end
                REMOVE_FOLLOW: begin
                    if (rem_cnt != '0) begin
                        act_nxt.remove = 1'b1;
                        rem_cnt_nxt    = rem_cnt - CNT_W'(1);
                        if (rem_cnt == CNT_W'(1)) begin
                            next_state = ret_state;
                        end
                    end else if (follow) begin
                        if (barrier) begin
                            act_nxt.remove = 1'b1;
                            rem_cnt_nxt    = CNT_W'(REMOVE_CYCLES - 1);
                            ret_state_nxt  = REMOVE_FOLLOW;
                        end else begin
                            act_nxt.front = !head;
                            follow_nxt    = 1'b0;
                            next_state    = SEARCH;
                        end
                    end else begin
                        next_state = SEARCH;
                    end
                end
                default: begin
                    next_state = RESETTING;
                end
            endcase
        end

        // Wall-following decision shared by SEARCH and FIRST_MOVE once a left wall is found
        if (search_dec) begin
            next_state = SEARCH;
            if (!left) begin
                act_nxt.turn = 1'b1;
                follow_nxt   = 1'b1;
                next_state   = REMOVE_FOLLOW;
            end else if (barrier) begin
                act_nxt.remove = 1'b1;
                rem_cnt_nxt    = CNT_W'(REMOVE_CYCLES - 1);
                ret_state_nxt  = SEARCH;
                next_state     = REMOVE_FOLLOW;
            end else if (!head) begin
                act_nxt.front = 1'b1;
            end else begin
                act_nxt.turn = 1'b1;
                rot_cnt_nxt  = CNT_W'(RIGHT_TURN_EXTRA);
                next_state   = ROTATE;
            end
        end
    end

endmodule

// File: tb/tb_robot.sv
// Bench for robot: directed scenarios with literal expectations, then random sensors
// checked every cycle against a queue-based model of locked actions and modes.
module tb_robot;

    logic clock = 1'b0;
    logic reset;
    logic head;
    logic left;
    logic under;
    logic barrier;
    logic front;
    logic turn;
    logic remove;

    int errors = 0;
    int checks = 0;

    typedef enum int {A_NONE, A_FRONT, A_TURN, A_REMOVE} act_e;
    typedef enum int {M_UNKNOWN, M_RESETTING, M_FIRST, M_SEARCH, M_FOLLOW, M_STANDBY} mode_e;

    act_e       locked[$];
    mode_e      mode = M_UNKNOWN;
    act_e       exp_act = A_NONE;
    logic [2:0] exp_state = 3'b000;

    robot dut (
        .clock   (clock),
        .reset   (reset),
        .head    (head),
        .left    (left),
        .under   (under),
        .barrier (barrier),
        .front   (front),
        .turn    (turn),
        .remove  (remove)
    );

    always #10 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [2:0] mode_code(input mode_e m);
        case (m)
            M_RESETTING: return 3'b101;
            M_FIRST:     return 3'b100;
            M_SEARCH:    return 3'b000;
            M_FOLLOW:    return 3'b010;
            M_STANDBY:   return 3'b011;
            default:     return 3'bxxx;
        endcase
    endfunction

    // A removal emits now and locks two more removal cycles; mode is where it returns to
    task automatic start_removal();
        exp_act = A_REMOVE;
        repeat (2) locked.push_back(A_REMOVE);
    endtask

    task automatic search_decide();
        if (!left) begin
            exp_act = A_TURN;
            mode    = M_FOLLOW;
        end else begin
            mode = M_SEARCH;
            if (barrier) start_removal();
            else if (!head) exp_act = A_FRONT;
            else begin
                exp_act = A_TURN;
                repeat (2) locked.push_back(A_TURN);
            end
        end
    endtask

    task automatic model_step();
        exp_act = A_NONE;
        if (reset) begin
            locked.delete();
            mode = M_RESETTING;
        end else if (mode == M_UNKNOWN) begin
            mode = M_UNKNOWN;
        end else if (mode == M_RESETTING) begin
            mode = M_FIRST;
        end else if (under) begin
            locked.delete();
            mode = M_STANDBY;
        end else if (locked.size() > 0) begin
            exp_act = locked.pop_front();
        end else begin
            case (mode)
                M_FIRST: begin
                    if (left) search_decide();
                    else if (barrier) start_removal();
                    else if (!head) exp_act = A_FRONT;
                    else exp_act = A_TURN;
                end
                M_SEARCH: search_decide();
                M_FOLLOW: begin
                    if (barrier) start_removal();
                    else begin
                        mode = M_SEARCH;
                        if (!head) exp_act = A_FRONT;
                    end
                end
                default: exp_act = A_NONE;
            endcase
        end
        if (locked.size() > 0) exp_state = (locked[0] == A_TURN) ? 3'b001 : 3'b010;
        else exp_state = mode_code(mode);
    endtask

    // Per-cycle compare against the model
    always @(posedge clock) begin
        model_step();
        #1;
        if (mode != M_UNKNOWN) begin
            check("front", 32'(front), 32'(exp_act == A_FRONT));
            check("turn", 32'(turn), 32'(exp_act == A_TURN));
            check("remove", 32'(remove), 32'(exp_act == A_REMOVE));
            check("act_state", 32'(dut.act_state), 32'(exp_state));
            check("one_action", 32'($countones({front, turn, remove}) <= 1), 32'(1));
        end
    end

    task automatic step(input logic r, input logic l, input logic h, input logic b, input logic u);
        @(negedge clock);
        reset   = r;
        left    = l;
        head    = h;
        barrier = b;
        under   = u;
        @(posedge clock);
        #2;
    endtask

    task automatic lit(input string name, input logic [2:0] st, input logic [2:0] ftr);
        check({name, "_state"}, 32'(dut.act_state), 32'(st));
        check({name, "_ftr"}, 32'({front, turn, remove}), 32'(ftr));
    endtask

    initial begin
        reset   = 1'b1;
        left    = 1'b0;
        head    = 1'b0;
        barrier = 1'b0;
        under   = 1'b0;
        @(posedge clock);
        #2;
        lit("reset", 3'b101, 3'b000);

        step(0, 0, 0, 0, 0);  lit("enter_first", 3'b100, 3'b000);
        step(0, 0, 0, 0, 0);  lit("first_front", 3'b100, 3'b100);
        step(0, 1, 0, 0, 0);  lit("first_to_search", 3'b000, 3'b100);

        step(0, 1, 1, 0, 0);  lit("rot1", 3'b001, 3'b010);
        step(0, 0, 0, 0, 0);  lit("rot2", 3'b001, 3'b010);
        step(0, 0, 0, 0, 0);  lit("rot3", 3'b000, 3'b010);
        step(0, 1, 0, 0, 0);  lit("after_rot", 3'b000, 3'b100);

        step(0, 1, 0, 1, 0);  lit("rem1", 3'b010, 3'b001);
        step(0, 0, 0, 0, 0);  lit("rem2", 3'b010, 3'b001);
        step(0, 0, 0, 0, 0);  lit("rem3", 3'b000, 3'b001);
        step(0, 1, 0, 0, 0);  lit("after_rem", 3'b000, 3'b100);

        step(0, 0, 0, 0, 0);  lit("follow_turn", 3'b010, 3'b010);
        step(0, 0, 0, 0, 0);  lit("follow_front", 3'b000, 3'b100);

        step(0, 1, 0, 1, 0);  lit("rem_abort1", 3'b010, 3'b001);
        step(1, 1, 0, 1, 0);  lit("rem_abort_rst", 3'b101, 3'b000);

        step(0, 0, 0, 0, 0);  lit("re_first", 3'b100, 3'b000);
        step(0, 0, 0, 0, 1);  lit("standby", 3'b011, 3'b000);
        repeat (3) begin
            step(0, 0, 0, 0, 0);
            lit("standby_hold", 3'b011, 3'b000);
        end
        step(1, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            logic r, u, l, b, h;
            r = ($urandom_range(0, 39) == 0);
            u = ($urandom_range(0, 49) == 0);
            l = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 3) == 0);
            h = b ? 1'b0 : 1'($urandom_range(0, 1));
            step(r, l, h, b, u);
        end

        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/robot.md
ROBOT -- requirements
Module: robot

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, named clock and reset.
REQ-002 clock  input  1  system clock (50 MHz); all state changes occur on its rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 head  input  1  wall (impassable cell or map edge) directly ahead.
REQ-005 left  input  1  wall directly to the robot's left.
REQ-006 under  input  1  robot stands on the target cell; stop.
REQ-007 barrier  input  1  removable trash directly ahead (head=0 when barrier=1).
REQ-008 front  output  1  move one cell forward this cycle.
REQ-009 turn  output  1  rotate 90 degrees counter-clockwise (left) this cycle.
REQ-010 remove  output  1  perform one trash-removal step this cycle.
REQ-011 The module SHALL have no parameters.

Function
REQ-012 The module SHALL hold 3-bit registers act_state and next_state (hierarchically visible), encoded SEARCH=000, ROTATE=001, REMOVE_FOLLOW=010, STAND_BY=011, FIRST_MOVE=100, RESETTING=101.
REQ-013 The module SHALL register its outputs: sensors sampled at rising edge N SHALL determine front/turn/remove valid after edge N; one action per cycle.
REQ-014 At most one of front, turn, remove SHALL be 1 in any cycle.
REQ-015 RESETTING SHALL drive all outputs 0, then go to FIRST_MOVE.
REQ-016 In every state except RESETTING, under=1 SHALL force STAND_BY with all outputs 0 (priority over all sensors except reset).
REQ-017 STAND_BY SHALL hold all outputs 0 until reset.
REQ-018 FIRST_MOVE with left=0: barrier=1 starts removal; else head=0 gives front=1; else turn=1; state stays FIRST_MOVE.
REQ-019 FIRST_MOVE with left=1 SHALL apply the SEARCH decision in the same cycle and enter SEARCH.
REQ-020 SEARCH priority: left=0 -> turn=1, go REMOVE_FOLLOW (follow pending); else barrier=1 -> start removal; else head=0 -> front=1, stay; else (head=1) -> turn=1, load rotation counter with 2, go ROTATE.
REQ-021 ROTATE SHALL emit turn=1 and decrement the counter each cycle; after the counter reaches 0 it SHALL return to SEARCH (total 3 left turns = one right turn).
REQ-022 Removal SHALL assert remove=1 for exactly 3 consecutive cycles in REMOVE_FOLLOW, then return to the state it started from (FIRST_MOVE or SEARCH), or to pending follow.
REQ-023 REMOVE_FOLLOW with follow pending: barrier=1 -> removal first; head=0 -> front=1, clear follow, go SEARCH; head=1 -> no action, go SEARCH.
REQ-024 Sensor changes during ROTATE or an active removal SHALL be ignored (except under and reset).
REQ-025 The rotation counter and removal counter SHALL each be 2 bits and SHALL never wrap.

Reset
REQ-026 reset=1 at a rising edge SHALL set act_state=RESETTING, all outputs 0, counters and follow flag 0, aborting any rotation or removal.
REQ-027 reset held high SHALL keep the module in RESETTING; the first edge with reset=0 SHALL enter FIRST_MOVE.

Structure
REQ-028 State codes, REMOVE_CYCLES=3 and RIGHT_TURN_EXTRA=2 SHALL live in a shared package robot_pkg.
REQ-029 The design SHALL be a single module with no sub-modules: one state register block, one next-state/output block.

Verification
REQ-030 Reset high 1 cycle, then FIRST_MOVE, left=0, head=0, barrier=0 -> front=1, act_state=100.
REQ-031 SEARCH, left=1, head=1 -> turn=1 for 3 consecutive cycles, then act_state=000.
REQ-032 SEARCH, left=1, barrier=1 -> remove=1 for exactly 3 cycles, then barrier=0, head=0 -> front=1.
REQ-033 SEARCH, left=0, head=0 -> turn=1 then front=1 on the next cycle, act_state back to 000.
REQ-034 under=1 in any non-reset state -> act_state=011, outputs 000 thereafter until reset.
REQ-035 reset=1 during second removal cycle -> act_state=101, remove=0 immediately after the edge.
